// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
// REG_DUMP_INDEX_EN prefixes each register's four value bytes with an index byte.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

`ifdef REG_DUMP_INDEX_EN
  localparam int BYTES_PER_REG = 5;
`else
  localparam int BYTES_PER_REG = 4;
`endif

  localparam int SHIFT_W = 8 * BYTES_PER_REG;
  localparam int BCNT_W  = 3;

  // Upper bits of the index byte; the register number fills the low five.
  localparam logic [2:0] INDEX_PREFIX = 3'b000;

endpackage

// File: rtl/reg_dump_word_serializer.sv
// Serializes one loaded register as a little-endian valid/ready byte stream.
// With REG_DUMP_INDEX_EN the index byte goes out ahead of the value bytes.
module word_serializer
  import reg_dump_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic [4:0]  load_index,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last_byte
);

  logic [SHIFT_W-1:0] shift;
  logic [BCNT_W-1:0]  bcnt;
  logic               valid;
  logic [SHIFT_W-1:0] load_value;
  logic               fire;

`ifdef REG_DUMP_INDEX_EN
  assign load_value = {load_word, INDEX_PREFIX, load_index};
`else
  logic unused_index;
  assign unused_index = ^load_index;
  assign load_value   = load_word;
`endif

  assign fire      = valid & tx_ready;
  assign last_byte = (bcnt == BCNT_W'(BYTES_PER_REG - 1));
  assign tx_data   = shift[7:0];
  // Valid is a register, so it never depends combinationally on tx_ready.
  assign tx_valid  = valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      bcnt  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shift <= load_value;
      bcnt  <= '0;
      valid <= 1'b1;
    end else if (fire) begin
      // Shifting zeros in leaves tx_data at 0 once the word is drained.
      shift <= shift >> 8;
      bcnt  <= bcnt + 1'b1;
      if (last_byte) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_dump.sv
// Debug readout engine: walks x0..x(NREGS-1) on a spare register-file read port
// and streams each register out as bytes. Optional index bytes: REG_DUMP_INDEX_EN.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  raddr,
  input  logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] LAST_INDEX = 5'(NREGS - 1);

  state_t      state, state_nxt;
  logic [4:0]  index, index_nxt;
  logic        load;
  logic        last_byte;
  logic        reg_sent;
  logic [31:0] load_word;

  // x0 reads as zero, matching how the core itself reads the register file.
  assign load_word = (index == 5'd0) ? 32'd0 : rdata;
  assign reg_sent  = tx_valid & tx_ready & last_byte;

  word_serializer u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_word  (load_word),
    .load_index (index),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .last_byte  (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    load      = 1'b0;
    raddr     = 5'd0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          index_nxt = 5'd0;
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        raddr     = index;
        load      = 1'b1;
        busy      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (reg_sent) begin
          if (index == LAST_INDEX) begin
            state_nxt = DONE;
          end else begin
            index_nxt = index + 5'd1;
            state_nxt = LATCH;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug readout engine for the CPUv1 register file. On a start pulse it walks the register file's read port from x0 to x(NREGS-1) and serializes each 32-bit value as bytes on a valid/ready byte stream, for a UART transmitter or test bench. It sits beside the decode stage on one spare read port, and reads registers the same way the core does: x0 returns zero.

## Interface
- NREGS, 32: registers dumped, x0..x(NREGS-1); legal 1..32.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start through the final byte handshake.
- done  out  1  one-cycle pulse the cycle after the last byte handshakes.
- raddr  out  5  register-file read address.
- rdata  in  32  register-file read data; combinational from raddr.
- tx_data  out  8  stream byte.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  stream ready from the consumer.

## Operation
- FSM states: IDLE, LATCH, SEND, DONE.
- IDLE: raddr=0, tx_valid=0. start=1 sets reg index 0 and moves to LATCH.
- LATCH, one cycle: raddr=index. Captures rdata into a 32-bit shift register, clears the byte counter, then moves to SEND.
- SEND: tx_valid=1 and tx_data = shift[7:0], so bytes go out little-endian.
  - On tx_valid & tx_ready: shift right by 8 and increment the byte counter.
  - After the handshake of the 4th byte: if index==NREGS-1, go to DONE; otherwise increment index and go to LATCH.
- DONE, one cycle: done=1, then IDLE.
- Each register is sampled at its own LATCH cycle. There is no global snapshot: writes landing during a dump appear for registers not yet latched.
- start while not IDLE is ignored; it is not queued.
- Total stream: 4*NREGS bytes (5*NREGS with the index feature enabled).

## Timing
- Reset values: busy=0, done=0, raddr=0, tx_valid=0, tx_data=0. FSM in IDLE, index 0, byte counter 0.
- start at cycle t gives LATCH at t+1 and the first tx_valid at t+2.
- With tx_ready held high: one byte per cycle, and 5 cycles per register (LATCH plus 4 bytes).
- Handshake rules:
  - tx_valid never drops, and tx_data never changes, until the handshake.
  - tx_valid does not depend combinationally on tx_ready.
  - tx_ready low stalls indefinitely with no loss.
- rst high in any state: next cycle IDLE with all outputs at their reset values. A partial dump is abandoned and no done pulse is produced.
- start and rst in the same cycle: rst wins.

## Configuration
- REG_DUMP_INDEX_EN defined:
  - Each register is preceded by one index byte {3'b000, index[4:0]}.
  - SEND emits 5 bytes per register; byte 0 is the index and bytes 1-4 are the value, little-endian.
  - Per-register cost becomes 6 cycles at full rate.
- Undefined: 4 value bytes per register only, with no index byte.

## Structure
- Shared package reg_dump_pkg:
  - FSM state typedef (IDLE/LATCH/SEND/DONE).
  - BYTES_PER_REG constant, 4 or 5 selected by REG_DUMP_INDEX_EN.
  - Index-byte prefix constant 3'b000.
- One sub-module, word_serializer:
  - Load port for a 32-bit word plus optional index.
  - Valid/ready byte output and a last_byte flag.
  - The top FSM handles only register sequencing.

## Test plan
- Reset mid-SEND of x3, byte 2 -> next cycle tx_valid=0, busy=0; no done; a new start dumps again from x0.
- Register file preloaded with x1=32'h11223344 and x2=32'hDEADBEEF, NREGS=3, tx_ready=1, start -> exact byte stream and timing:
  - Bytes in order: 00 00 00 00 44 33 22 11 EF BE AD DE.
  - First tx_valid at t+2.
  - done pulses exactly once, the cycle after the 12th handshake.
- Same preload with tx_ready toggling pseudo-randomly -> identical byte sequence; tx_data stable whenever tx_valid=1 and tx_ready=0.
- start pulsed again while busy -> ignored; exactly 4*NREGS bytes are emitted.
- x5 written with 32'hCAFEF00D while x2 is being sent, NREGS=8 -> the stream shows the new x5 value.
- REG_DUMP_INDEX_EN defined, NREGS=2, x1=32'h000000AB -> stream 00 00 00 00 00 01 AB 00 00 00 and 10 handshakes.
